pipe_stall_ctrl: RTL and testbench
==================================

Name: pipe_stall_ctrl

Overview:
Central stall/flush sequencer for the 5-stage MIPS32 pipeline (IF, ID, EX, MEM, WB). It detects load-use hazards between ID and EX and sequences multi-cycle EX operations (mult/div) through a counter FSM. It drives per-stage hold and bubble controls consumed by the PC, IF-ID, ID-EX, EX-MEM and MEM-WB registers, and it handles pipeline-wide flush.

Parameters:
MC_CNT_W, 6, width of the multi-cycle latency request and internal down-counter
PERF_W, 32, width of the optional stall performance counters

Ports:
clk  in  1  system clock; all state updates on rising edge
rst  in  1  synchronous reset, active-high
id_reg1_rd_en  in  1  ID reads rs
id_reg1_addr  in  5  ID rs address
id_reg2_rd_en  in  1  ID reads rt
id_reg2_addr  in  5  ID rt address
ex_is_load  in  1  instruction in EX is a load
ex_write_en  in  1  instruction in EX writes a register
ex_write_addr  in  5  EX destination register
ex_mc_start  in  1  EX holds a multi-cycle op (level, held while stalled)
ex_mc_cycles  in  MC_CNT_W  required EX cycles for that op
flush_i  in  1  exception/eret flush request
stall_o  out  5  hold: [0] PC, [1] IF-ID, [2] ID-EX, [3] EX-MEM, [4] MEM-WB
ex_bubble_o  out  1  ID-EX loads NOP this cycle
mem_bubble_o  out  1  EX-MEM loads NOP this cycle
flush_o  out  1  all pipeline registers clear this cycle
ex_mc_done_o  out  1  EX op result valid; EX advances this cycle
mc_busy_o  out  1  FSM not IDLE
perf_lu_cnt_o  out  PERF_W  load-use stall cycles (optional feature)
perf_mc_cnt_o  out  PERF_W  multi-cycle stall cycles (optional feature)

Behaviour:
- Clock and reset: single clock clk; rst is synchronous and active-high. Reset forces state IDLE, counter 0, perf counters 0.
- Output timing: outputs are combinational from registered state plus current inputs; there is zero-cycle latency from hazard to stall.
- Outputs while rst=1: all outputs 0.
- FSM states IDLE, RUN, DONE. N_eff = (ex_mc_cycles==0) ? 1 : ex_mc_cycles.
- IDLE with ex_mc_start=1:
  - mc stall this cycle; cnt <= N_eff-1.
  - Next state DONE if N_eff==1, else RUN.
- RUN:
  - mc stall; cnt <= cnt-1.
  - Next state DONE when cnt==1.
- DONE:
  - No mc stall; ex_mc_done_o=1; next state IDLE.
  - ex_mc_start is ignored in DONE and RUN; it is sampled only in IDLE.
- Cycle count: total mc-stall cycles equal N_eff exactly, followed by one DONE cycle.
- mc stall outputs: stall_o=5'b01111, mem_bubble_o=1, ex_bubble_o=0.
- Load-use hazard: ex_is_load & ex_write_en & ex_write_addr!=0 & ((id_reg1_rd_en & addr1 match) | (id_reg2_rd_en & addr2 match)).
  - Outputs: stall_o=5'b00111, ex_bubble_o=1.
  - Duration is one cycle, since the bubble removes the load match.
- Priority: flush > mc stall > load-use.
  - Load-use is masked whenever an mc stall is active.
  - In DONE, load-use is evaluated normally.
- Flush (flush_i=1):
  - flush_o=1; stall_o=0; both bubbles 0; ex_mc_done_o=0.
  - At the edge: state <= IDLE and cnt <= 0, aborting any RUN/DONE.
  - ex_mc_start in the same cycle is discarded.
- mc_busy_o = (state != IDLE).
- Counter: cnt never underflows; it is not decremented outside RUN.
- Hazard on $0: register 0 never causes a hazard.

Optional Feature:
STALL_PERF_EN:
- Defined: perf_lu_cnt_o increments each cycle that a load-use stall is output; perf_mc_cnt_o increments each mc-stall cycle.
  - Counters saturate at all-ones.
  - Both clear on rst; neither counts during flush.
- Undefined: both ports are tied to 0 and no counter flops are inferred.

Test Plan:
- Load-use: EX lw $5 (load=1, we=1, waddr=5), ID reads rs=5 -> stall_o=00111 and ex_bubble_o=1 for exactly one cycle, then 00000.
- Hazard on $0 and disabled reads: waddr=0, or rd_en=0 with addr=5 -> no stall.
- Multi-cycle: ex_mc_start=1, cycles=3 held -> stall_o=01111 and mem_bubble_o=1 for 3 cycles, then ex_mc_done_o=1 for 1 cycle, then IDLE. Repeat with cycles=0 and cycles=1 -> 1 stall cycle then DONE.
- Flush mid-op: start cycles=10, assert flush_i at cycle 4 -> flush_o=1, stall_o=0, next cycle mc_busy_o=0, no ex_mc_done_o.
- Priority: simultaneous load-use match and mc in RUN -> stall_o=01111, ex_bubble_o=0. Simultaneous flush_i and start -> flush only, state stays IDLE.
- STALL_PERF_EN: 1 load-use plus a cycles=5 op -> perf_lu_cnt_o=1, perf_mc_cnt_o=5. Preload near saturation by forcing -> holds at all-ones. rst mid-op -> all outputs and counters 0 on the next cycle.

Source files
------------

// File: rtl/pipe_stall_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use detection and multi-cycle EX sequencing.
// Optional stall performance counters are enabled by defining STALL_PERF_EN.
module pipe_stall_ctrl #(
    parameter int MC_CNT_W = 6,
    parameter int PERF_W   = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                id_reg1_rd_en,
    input  logic [4:0]          id_reg1_addr,
    input  logic                id_reg2_rd_en,
    input  logic [4:0]          id_reg2_addr,
    input  logic                ex_is_load,
    input  logic                ex_write_en,
    input  logic [4:0]          ex_write_addr,
    input  logic                ex_mc_start,
    input  logic [MC_CNT_W-1:0] ex_mc_cycles,
    input  logic                flush_i,
    output logic [4:0]          stall_o,
    output logic                ex_bubble_o,
    output logic                mem_bubble_o,
    output logic                flush_o,
    output logic                ex_mc_done_o,
    output logic                mc_busy_o,
    output logic [PERF_W-1:0]   perf_lu_cnt_o,
    output logic [PERF_W-1:0]   perf_mc_cnt_o
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t              state_q, state_d;
    logic [MC_CNT_W-1:0] cnt_q, cnt_d;
    logic [MC_CNT_W-1:0] n_eff;
    logic                lu_hazard;
    logic                mc_stall;
    logic                mc_done;
    logic                lu_stall;

    // A zero-cycle request still costs one stall cycle.
    assign n_eff = (ex_mc_cycles == '0) ? MC_CNT_W'(1) : ex_mc_cycles;

    assign lu_hazard = ex_is_load && ex_write_en && (ex_write_addr != 5'd0) &&
                       ((id_reg1_rd_en && (id_reg1_addr == ex_write_addr)) ||
                        (id_reg2_rd_en && (id_reg2_addr == ex_write_addr)));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        mc_stall = 1'b0;
        mc_done  = 1'b0;
        if (flush_i) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (ex_mc_start) begin
                        mc_stall = 1'b1;
                        cnt_d    = n_eff - MC_CNT_W'(1);
                        state_d  = (n_eff == MC_CNT_W'(1)) ? DONE : RUN;
                    end
                end
                RUN: begin
                    mc_stall = 1'b1;
                    if (cnt_q != '0) begin
                        cnt_d = cnt_q - MC_CNT_W'(1);
                    end
                    if (cnt_q <= MC_CNT_W'(1)) begin
                        state_d = DONE;
                    end
                end
                DONE: begin
                    mc_done = 1'b1;
                    state_d = IDLE;
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
        lu_stall = lu_hazard && !mc_stall && !flush_i;
    end

    always_comb begin
        stall_o      = 5'b00000;
        ex_bubble_o  = 1'b0;
        mem_bubble_o = 1'b0;
        flush_o      = 1'b0;
        ex_mc_done_o = 1'b0;
        mc_busy_o    = 1'b0;
        if (!rst) begin
            mc_busy_o    = (state_q != IDLE);
            ex_mc_done_o = mc_done;
            if (flush_i) begin
                flush_o = 1'b1;
            end else if (mc_stall) begin
                stall_o      = 5'b01111;
                mem_bubble_o = 1'b1;
            end else if (lu_stall) begin
                stall_o     = 5'b00111;
                ex_bubble_o = 1'b1;
            end
        end
    end

`ifdef STALL_PERF_EN
    logic [PERF_W-1:0] perf_lu_q, perf_mc_q;

    // Saturating counters; flush cycles never raise either stall flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_lu_q <= '0;
            perf_mc_q <= '0;
        end else begin
            if (lu_stall && (perf_lu_q != '1)) begin
                perf_lu_q <= perf_lu_q + PERF_W'(1);
            end
            if (mc_stall && !flush_i && (perf_mc_q != '1)) begin
                perf_mc_q <= perf_mc_q + PERF_W'(1);
            end
        end
    end

    assign perf_lu_cnt_o = rst ? '0 : perf_lu_q;
    assign perf_mc_cnt_o = rst ? '0 : perf_mc_q;
`else
    assign perf_lu_cnt_o = '0;
    assign perf_mc_cnt_o = '0;
`endif

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Self-checking bench for pipe_stall_ctrl: vector table, directed multi-cycle sequences and a
// randomized run against an operation-level reference model.
module tb_pipe_stall_ctrl;

    localparam int MCW   = 6;
    localparam int TB_PW = 4;
`ifdef STALL_PERF_EN
    localparam bit PERF_ON = 1'b1;
`else
    localparam bit PERF_ON = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst;
    logic             r1en, r2en, ld, we, start, flush;
    logic [4:0]       a1, a2, wa;
    logic [MCW-1:0]   cyc;
    logic [4:0]       stall_o;
    logic             ex_bubble_o, mem_bubble_o, flush_o, ex_mc_done_o, mc_busy_o;
    logic [TB_PW-1:0] perf_lu_cnt_o, perf_mc_cnt_o;

    int checks = 0;
    int errors = 0;

    // Reference model: stall cycles still owed by the current op, and a pending "result ready" cycle.
    int m_rem = 0;
    bit m_done = 1'b0;
    int m_lu_cnt = 0;
    int m_mc_cnt = 0;
    logic [4:0] e_stall;
    logic e_exb, e_memb, e_flush, e_done, e_busy, e_mc, e_lu;

    always #5 clk = ~clk;

    pipe_stall_ctrl #(.MC_CNT_W(MCW), .PERF_W(TB_PW)) dut (
        .clk(clk), .rst(rst),
        .id_reg1_rd_en(r1en), .id_reg1_addr(a1),
        .id_reg2_rd_en(r2en), .id_reg2_addr(a2),
        .ex_is_load(ld), .ex_write_en(we), .ex_write_addr(wa),
        .ex_mc_start(start), .ex_mc_cycles(cyc), .flush_i(flush),
        .stall_o(stall_o), .ex_bubble_o(ex_bubble_o), .mem_bubble_o(mem_bubble_o),
        .flush_o(flush_o), .ex_mc_done_o(ex_mc_done_o), .mc_busy_o(mc_busy_o),
        .perf_lu_cnt_o(perf_lu_cnt_o), .perf_mc_cnt_o(perf_mc_cnt_o)
    );

    typedef struct {
        logic       r1en; logic [4:0] a1;
        logic       r2en; logic [4:0] a2;
        logic       ld; logic we; logic [4:0] wa;
        logic       start; logic flush;
        logic [4:0] x_stall; logic x_exb; logic x_flush;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic set_in(input logic i_r1en, input logic [4:0] i_a1, input logic i_r2en,
                          input logic [4:0] i_a2, input logic i_ld, input logic i_we,
                          input logic [4:0] i_wa);
        r1en = i_r1en; a1 = i_a1; r2en = i_r2en; a2 = i_a2; ld = i_ld; we = i_we; wa = i_wa;
    endtask

    function automatic int sat(input int v);
        return (v >= (1 << TB_PW) - 1) ? (1 << TB_PW) - 1 : v + 1;
    endfunction

    // Wait for the falling edge, derive expectations from the model and compare every output.
    task automatic eval_cycle();
        int n;
        @(negedge clk);
        e_stall = 5'b0; e_exb = 0; e_memb = 0; e_flush = 0; e_done = 0; e_busy = 0;
        e_mc = 0; e_lu = 0;
        if (!rst) begin
            e_busy = (m_rem > 0) || m_done;
            if (flush) begin
                e_flush = 1'b1;
            end else begin
                if (m_done) e_done = 1'b1;
                else if (m_rem > 0 || start) e_mc = 1'b1;
                e_lu = !e_mc && ld && we && (wa != 0) &&
                       ((r1en && a1 == wa) || (r2en && a2 == wa));
                if (e_mc) begin
                    e_stall = 5'b01111; e_memb = 1'b1;
                end else if (e_lu) begin
                    e_stall = 5'b00111; e_exb = 1'b1;
                end
            end
        end
        chk("model_outputs", {26'd0, stall_o, ex_bubble_o, mem_bubble_o, flush_o, ex_mc_done_o, mc_busy_o},
            {26'd0, e_stall, e_exb, e_memb, e_flush, e_done, e_busy});
        n = (PERF_ON && !rst) ? m_lu_cnt : 0;
        chk("model_perf_lu", 32'(perf_lu_cnt_o), 32'(n));
        n = (PERF_ON && !rst) ? m_mc_cnt : 0;
        chk("model_perf_mc", 32'(perf_mc_cnt_o), 32'(n));
    endtask

    // Advance one clock and move the model forward by the same inputs.
    task automatic tick();
        int n;
        @(posedge clk);
        if (rst) begin
            m_rem = 0; m_done = 0; m_lu_cnt = 0; m_mc_cnt = 0;
        end else if (flush) begin
            m_rem = 0; m_done = 0;
        end else begin
            if (e_lu) m_lu_cnt = sat(m_lu_cnt);
            if (e_mc) m_mc_cnt = sat(m_mc_cnt);
            if (m_done) begin
                m_done = 0;
            end else if (m_rem > 0) begin
                m_rem--;
                if (m_rem == 0) m_done = 1;
            end else if (start) begin
                n = (cyc == 0) ? 1 : int'(cyc);
                m_rem = n - 1;
                if (m_rem == 0) m_done = 1;
            end
        end
        #1;
    endtask

    vec_t tbl[10];
    int   exp_n[3];
    logic [MCW-1:0] cyc_list[3];

    initial begin
        rst = 1'b1; start = 0; cyc = '0; flush = 0;
        set_in(0, 0, 0, 0, 0, 0, 0);

        // Reset: everything low, even with hazard and start present.
        set_in(1, 5, 0, 0, 1, 1, 5); start = 1; cyc = 6'd3;
        eval_cycle();
        chk("rst_stall", 32'(stall_o), 0);
        chk("rst_busy", 32'(mc_busy_o), 0);
        tick();
        tick();
        rst = 0; start = 0;
        set_in(0, 0, 0, 0, 0, 0, 0);

        tbl[0] = '{1, 5, 0, 0, 1, 1, 5, 0, 0, 5'b00111, 1, 0};
        tbl[1] = '{0, 0, 1, 7, 1, 1, 7, 0, 0, 5'b00111, 1, 0};
        tbl[2] = '{1, 0, 1, 0, 1, 1, 0, 0, 0, 5'b00000, 0, 0};
        tbl[3] = '{0, 5, 0, 5, 1, 1, 5, 0, 0, 5'b00000, 0, 0};
        tbl[4] = '{1, 5, 0, 0, 0, 1, 5, 0, 0, 5'b00000, 0, 0};
        tbl[5] = '{1, 5, 0, 0, 1, 0, 5, 0, 0, 5'b00000, 0, 0};
        tbl[6] = '{1, 4, 1, 6, 1, 1, 5, 0, 0, 5'b00000, 0, 0};
        tbl[7] = '{1, 5, 0, 0, 1, 1, 5, 0, 1, 5'b00000, 0, 1};
        tbl[8] = '{1, 5, 0, 0, 1, 1, 5, 1, 1, 5'b00000, 0, 1};
        tbl[9] = '{1, 9, 1, 9, 1, 1, 9, 0, 0, 5'b00111, 1, 0};
        for (int i = 0; i < 10; i++) begin
            set_in(tbl[i].r1en, tbl[i].a1, tbl[i].r2en, tbl[i].a2, tbl[i].ld, tbl[i].we, tbl[i].wa);
            start = tbl[i].start; cyc = 6'd4; flush = tbl[i].flush;
            eval_cycle();
            chk("vec_stall", 32'(stall_o), 32'(tbl[i].x_stall));
            chk("vec_ex_bubble", 32'(ex_bubble_o), 32'(tbl[i].x_exb));
            chk("vec_flush", 32'(flush_o), 32'(tbl[i].x_flush));
            chk("vec_mem_bubble", 32'(mem_bubble_o), 0);
            $display("vec %0d stall=%b exb=%b flush=%b", i, stall_o, ex_bubble_o, flush_o);
            tick();
        end
        start = 0; flush = 0;
        eval_cycle();
        chk("flush_start_idle", 32'(mc_busy_o), 0);
        tick();

        // Load-use lasts one cycle: the bubble removes the load from EX.
        set_in(1, 5, 0, 0, 1, 1, 5);
        eval_cycle();
        chk("lu_stall", 32'(stall_o), 32'(5'b00111));
        tick();
        ld = 0; we = 0; wa = 0;
        eval_cycle();
        chk("lu_release", 32'(stall_o), 0);
        tick();
        $display("seq load_use done");

        cyc_list[0] = 6'd3; cyc_list[1] = 6'd0; cyc_list[2] = 6'd1;
        exp_n[0] = 3; exp_n[1] = 1; exp_n[2] = 1;
        for (int k = 0; k < 3; k++) begin
            set_in(0, 0, 0, 0, 0, 0, 0);
            start = 1; cyc = cyc_list[k];
            for (int i = 0; i < exp_n[k]; i++) begin
                eval_cycle();
                chk("mc_stall", 32'(stall_o), 32'(5'b01111));
                chk("mc_mem_bubble", 32'(mem_bubble_o), 1);
                tick();
            end
            eval_cycle();
            chk("mc_done", 32'(ex_mc_done_o), 1);
            chk("mc_done_nostall", 32'(stall_o), 0);
            tick();
            start = 0;
            eval_cycle();
            chk("mc_idle", 32'(mc_busy_o), 0);
            tick();
            $display("seq mc cycles=%0d done", cyc_list[k]);
        end

        // Flush in the middle of a long op.
        start = 1; cyc = 6'd10;
        for (int i = 0; i < 4; i++) begin
            eval_cycle();
            tick();
        end
        flush = 1;
        eval_cycle();
        chk("flush_o", 32'(flush_o), 1);
        chk("flush_stall", 32'(stall_o), 0);
        chk("flush_done", 32'(ex_mc_done_o), 0);
        tick();
        flush = 0; start = 0;
        for (int i = 0; i < 8; i++) begin
            eval_cycle();
            chk("post_flush_busy", 32'(mc_busy_o), 0);
            chk("post_flush_done", 32'(ex_mc_done_o), 0);
            tick();
        end
        $display("seq flush_mid_op done");

        // mc stall masks load-use in RUN; load-use is live again in DONE.
        start = 1; cyc = 6'd3;
        eval_cycle();
        tick();
        set_in(0, 0, 1, 8, 1, 1, 8);
        eval_cycle();
        chk("prio_run_stall", 32'(stall_o), 32'(5'b01111));
        chk("prio_run_exb", 32'(ex_bubble_o), 0);
        tick();
        eval_cycle();
        tick();
        eval_cycle();
        chk("prio_done_flag", 32'(ex_mc_done_o), 1);
        chk("prio_done_lu", 32'(stall_o), 32'(5'b00111));
        tick();
        start = 0;
        set_in(0, 0, 0, 0, 0, 0, 0);
        eval_cycle();
        tick();
        $display("seq priority done");

        // Performance counters: one load-use plus a 5-cycle op, then saturation.
        rst = 1;
        eval_cycle();
        tick();
        rst = 0;
        set_in(1, 3, 0, 0, 1, 1, 3);
        eval_cycle();
        tick();
        set_in(0, 0, 0, 0, 0, 0, 0);
        start = 1; cyc = 6'd5;
        for (int i = 0; i < 6; i++) begin
            eval_cycle();
            tick();
        end
        start = 0;
        eval_cycle();
        chk("perf_lu_one", 32'(perf_lu_cnt_o), PERF_ON ? 1 : 0);
        chk("perf_mc_five", 32'(perf_mc_cnt_o), PERF_ON ? 5 : 0);
        tick();
        set_in(1, 3, 0, 0, 1, 1, 3);
        for (int i = 0; i < 20; i++) begin
            eval_cycle();
            tick();
        end
        set_in(0, 0, 0, 0, 0, 0, 0);
        eval_cycle();
        chk("perf_lu_sat", 32'(perf_lu_cnt_o), PERF_ON ? 32'((1 << TB_PW) - 1) : 0);
        tick();
        $display("seq perf done");

        // Reset mid-op clears everything.
        start = 1; cyc = 6'd6;
        for (int i = 0; i < 2; i++) begin
            eval_cycle();
            tick();
        end
        rst = 1;
        eval_cycle();
        chk("rst_mid_stall", 32'(stall_o), 0);
        chk("rst_mid_memb", 32'(mem_bubble_o), 0);
        tick();
        rst = 0; start = 0;
        eval_cycle();
        chk("rst_mid_busy", 32'(mc_busy_o), 0);
        chk("rst_mid_perf_mc", 32'(perf_mc_cnt_o), 0);
        tick();
        $display("seq reset_mid_op done");

        for (int i = 0; i < 500; i++) begin
            rst   = ($urandom_range(0, 59) == 0);
            flush = ($urandom_range(0, 29) == 0);
            start = ($urandom_range(0, 4) == 0);
            cyc   = MCW'($urandom_range(0, 6));
            set_in(1'($urandom), 5'($urandom_range(0, 3)), 1'($urandom), 5'($urandom_range(0, 3)),
                   1'($urandom), 1'($urandom), 5'($urandom_range(0, 3)));
            eval_cycle();
            tick();
        end
        $display("seq random done");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
